// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus definitions: PPU/APU register map and the OAM DMA state encoding.
package nes_bus_pkg;

  // PPU register window ($2000-$2007)
  localparam logic [15:0] PPU_CTRL_ADDR   = 16'h2000;
  localparam logic [15:0] PPU_MASK_ADDR   = 16'h2001;
  localparam logic [15:0] PPU_STATUS_ADDR = 16'h2002;
  localparam logic [15:0] OAM_ADDR_ADDR   = 16'h2003;
  localparam logic [15:0] PPU_SCROLL_ADDR = 16'h2005;
  localparam logic [15:0] PPU_ADDR_ADDR   = 16'h2006;
  localparam logic [15:0] PPU_DATA_ADDR   = 16'h2007;

  // APU / IO registers
  localparam logic [15:0] APU_STATUS_ADDR = 16'h4015;
  localparam logic [15:0] JOY1_ADDR       = 16'h4016;
  localparam logic [15:0] JOY2_ADDR       = 16'h4017;

  // Defaults for the OAM DMA controller
  localparam logic [15:0] DEF_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] DEF_OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA controller and CPU bus arbiter. Copies one 256-byte page to the
// OAM data port while holding the CPU off the bus via RDY.
//
// state | meaning
// IDLE  | CPU owns the bus, watching for a write to the DMA register
// HALT  | RDY low, CPU still on the bus until its first read cycle
// ALIGN | DMA owns the bus, dummy read until the next cycle is a "get" cycle
// READ  | fetch byte {page, idx} into the latch
// WRITE | store latch to the OAM data port, advance idx
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DEF_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_r_w,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_r_w,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active
);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  latch;
  logic        par;
  logic        trigger;

  assign trigger = (cpu_r_w == 1'b0) && (cpu_addr == DMA_REG_ADDR);

  // Sequencer: parity flop, transfer FSM, page/index counters and data latch
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
      page  <= 8'h00;
      idx   <= 8'h00;
      latch <= 8'h00;
      par   <= 1'b0;
    end else begin
      par <= ~par;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            page  <= cpu_wdata;
            idx   <= 8'h00;
            state <= HALT;
          end
        end
        HALT: begin
          // The 6502 only honours RDY on reads, so writes keep it running here.
          if (cpu_r_w) state <= ALIGN;
        end
        ALIGN: begin
          // Leave on an odd cycle so every READ lands on a "get" (par==0) cycle.
          if (par) state <= READ;
        end
        READ: begin
          latch <= bus_rdata;
          state <= WRITE;
        end
        WRITE: begin
          idx <= idx + 8'd1;
          if (idx == 8'hFF) state <= IDLE;
          else              state <= READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bus mux and handshake outputs, decoded from the registered state
  always_comb begin
    cpu_rdy    = (state == IDLE);
    dma_active = 1'b0;
    bus_addr   = cpu_addr;
    bus_wdata  = cpu_wdata;
    bus_r_w    = cpu_r_w;
    unique case (state)
      ALIGN: begin
        dma_active = 1'b1;
        bus_addr   = cpu_addr;
        bus_r_w    = 1'b1;
        bus_wdata  = latch;
      end
      READ: begin
        dma_active = 1'b1;
        bus_addr   = {page, idx};
        bus_r_w    = 1'b1;
        bus_wdata  = latch;
      end
      WRITE: begin
        dma_active = 1'b1;
        bus_addr   = OAM_DATA_ADDR;
        bus_r_w    = 1'b0;
        bus_wdata  = latch;
      end
      default: begin
        dma_active = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: RAM model, OAM write scoreboard, scenario tasks.
module tb_oam_dma;
  import nes_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_r_w;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_r_w;
  logic [7:0]  bus_rdata;
  logic        dma_active;

  int checks = 0;
  int errors = 0;
  int oam_wr = 0;
  logic [7:0] exp_q[$];
  logic       tb_par;
  logic       ram_ready = 1'b0;
  logic [7:0] mem [0:65535];

  oam_dma dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_r_w    (cpu_r_w),
    .cpu_rdy    (cpu_rdy),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_r_w    (bus_r_w),
    .bus_rdata  (bus_rdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Source pattern: page $02 holds i^5A; other pages are distinct from it
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'h02);
  endfunction

  // RAM model: async read, write on clock edge
  assign bus_rdata = mem[bus_addr];
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_byte(16'(i));
      ram_ready <= 1'b1;
    end else if (reset_l && !bus_r_w) begin
      mem[bus_addr] <= bus_wdata;
    end
  end

  // Reference parity: toggles every clock from reset
  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) tb_par <= 1'b0;
    else          tb_par <= ~tb_par;
  end

  // Scoreboard: every write to the OAM data port pops one expected byte
  always @(negedge clk) begin
    logic [7:0] e;
    if (reset_l && bus_r_w == 1'b0 && bus_addr == 16'h2004) begin
      oam_wr++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL oam_extra_write got %h expected no write", bus_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus_wdata !== e) begin
          errors++;
          $display("FAIL oam_data got %h expected %h", bus_wdata, e);
        end
      end
    end
  end

  task automatic cpu_idle();
    cpu_addr  = 16'h8000;
    cpu_r_w   = 1'b1;
    cpu_wdata = 8'h00;
  endtask

  // Runs one transfer from trigger to CPU release and measures its timing.
  // Entered and left at posedge+1.
  task automatic run_dma(input logic [7:0] page, input logic want_par, input int nw,
                         input bit retrig, output int rdy_low, output int align_cnt,
                         output int own_cnt, output int halt_cnt, output int first_read,
                         output logic [15:0] last_read, output bit timeout);
    bit done, pend, fired, seen;
    rdy_low = 0; align_cnt = 0; own_cnt = 0; halt_cnt = 0; first_read = -1;
    last_read = 16'h0000; done = 0; pend = 0; fired = 0; seen = 0;
    if (tb_par !== want_par) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 256; i++) exp_q.push_back(init_byte({page, 8'(i)}));
    cpu_addr = 16'h4014; cpu_r_w = 1'b0; cpu_wdata = page;
    for (int k = 0; k < 1200 && !done; k++) begin
      if (k > 0) begin
        if (k <= nw) begin
          cpu_addr = 16'h01FE - 16'(k); cpu_r_w = 1'b0; cpu_wdata = 8'hC0 + 8'(k);
        end else if (pend) begin
          cpu_addr = 16'h4014; cpu_r_w = 1'b0; cpu_wdata = 8'h07; pend = 0;
        end else begin
          cpu_idle();
        end
      end
      @(negedge clk);
      if (!cpu_rdy) begin rdy_low++; seen = 1; end
      if (dma_active) own_cnt++;
      if (dut.state == ALIGN) align_cnt++;
      if (dut.state == HALT) halt_cnt++;
      if (dut.state == READ) begin
        if (first_read < 0) first_read = k;
        last_read = bus_addr;
      end
      if (retrig && !fired && dut.state == WRITE && dut.idx == 8'h10) begin
        pend = 1; fired = 1;
      end
      if (seen && cpu_rdy) done = 1;
      else begin @(posedge clk); #1; end
    end
    timeout = !done;
    @(posedge clk); #1;
    cpu_idle();
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    cpu_addr = 16'h1234; cpu_wdata = 8'h99; cpu_r_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b expected 1", cpu_rdy); end
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b expected 0", dma_active); end
    checks++; if (bus_addr !== 16'h1234) begin errors++; $display("FAIL reset_addr got %h expected 1234", bus_addr); end
    checks++; if (bus_wdata !== 8'h99) begin errors++; $display("FAIL reset_wdata got %h expected 99", bus_wdata); end
    checks++; if (bus_r_w !== 1'b0) begin errors++; $display("FAIL reset_rw got %b expected 0", bus_r_w); end
    cpu_idle();
    reset_l = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL idle_rdy got %b expected 1", cpu_rdy); end
    checks++; if (bus_addr !== 16'h8000) begin errors++; $display("FAIL idle_pass got %h expected 8000", bus_addr); end
  endtask

  task automatic test_even();
    int rl, al, ow, hl, fr; logic [15:0] lr; bit to;
    run_dma(8'h02, 1'b1, 0, 0, rl, al, ow, hl, fr, lr, to);
    checks++; if (to) begin errors++; $display("FAIL even_timeout got 1 expected 0"); end
    checks++; if (al != 1) begin errors++; $display("FAIL even_align got %0d expected 1", al); end
    checks++; if (rl != 514) begin errors++; $display("FAIL even_rdy_low got %0d expected 514", rl); end
    checks++; if (ow != 513) begin errors++; $display("FAIL even_own got %0d expected 513", ow); end
    checks++; if (fr != 3) begin errors++; $display("FAIL even_first_read got %0d expected 3", fr); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL even_count left %0d expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_odd();
    int rl, al, ow, hl, fr; logic [15:0] lr; bit to;
    run_dma(8'h02, 1'b0, 0, 0, rl, al, ow, hl, fr, lr, to);
    checks++; if (to) begin errors++; $display("FAIL odd_timeout got 1 expected 0"); end
    checks++; if (al != 2) begin errors++; $display("FAIL odd_align got %0d expected 2", al); end
    checks++; if (ow != 514) begin errors++; $display("FAIL odd_own got %0d expected 514", ow); end
    checks++; if (rl != 515) begin errors++; $display("FAIL odd_rdy_low got %0d expected 515", rl); end
    checks++; if (fr != 4) begin errors++; $display("FAIL odd_first_read got %0d expected 4", fr); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL odd_count left %0d expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_halt_writes();
    int rl, al, ow, hl, fr; logic [15:0] lr; bit to;
    run_dma(8'h02, 1'b1, 2, 0, rl, al, ow, hl, fr, lr, to);
    checks++; if (to) begin errors++; $display("FAIL halt_timeout got 1 expected 0"); end
    checks++; if (hl != 3) begin errors++; $display("FAIL halt_cycles got %0d expected 3", hl); end
    checks++; if (mem[16'h01FD] !== 8'hC1) begin errors++; $display("FAIL halt_push1 got %h expected c1", mem[16'h01FD]); end
    checks++; if (mem[16'h01FC] !== 8'hC2) begin errors++; $display("FAIL halt_push2 got %h expected c2", mem[16'h01FC]); end
    checks++; if (fr != 5) begin errors++; $display("FAIL halt_first_read got %0d expected 5", fr); end
    checks++; if (rl != 516) begin errors++; $display("FAIL halt_rdy_low got %0d expected 516", rl); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL halt_count left %0d expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_retrigger();
    int rl, al, ow, hl, fr; logic [15:0] lr; bit to;
    run_dma(8'h02, 1'b1, 0, 1, rl, al, ow, hl, fr, lr, to);
    checks++; if (to) begin errors++; $display("FAIL retrig_timeout got 1 expected 0"); end
    checks++; if (dut.page !== 8'h02) begin errors++; $display("FAIL retrig_page got %h expected 02", dut.page); end
    checks++; if (rl != 514) begin errors++; $display("FAIL retrig_rdy_low got %0d expected 514", rl); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL retrig_count left %0d expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_page_wrap();
    int rl, al, ow, hl, fr; logic [15:0] lr; bit to;
    run_dma(8'hFF, 1'b1, 0, 0, rl, al, ow, hl, fr, lr, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout got 1 expected 0"); end
    checks++; if (lr !== 16'hFFFF) begin errors++; $display("FAIL wrap_last_read got %h expected ffff", lr); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL wrap_rdy got %b expected 1", cpu_rdy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_count left %0d expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int base, at_rst, guard;
    exp_q.delete();
    base = oam_wr;
    for (int i = 0; i < 256; i++) exp_q.push_back(init_byte({8'h02, 8'(i)}));
    cpu_addr = 16'h4014; cpu_r_w = 1'b0; cpu_wdata = 8'h02;
    @(posedge clk); #1;
    cpu_idle();
    guard = 0;
    while ((oam_wr - base) < 64 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if ((oam_wr - base) != 64) begin errors++; $display("FAIL mid_writes_before got %0d expected 64", oam_wr - base); end
    #2 reset_l = 1'b0;
    #1;
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy got %b expected 1", cpu_rdy); end
    checks++; if (dma_active !== 1'b0) begin errors++; $display("FAIL mid_active got %b expected 0", dma_active); end
    checks++; if (bus_addr !== 16'h8000) begin errors++; $display("FAIL mid_addr got %h expected 8000", bus_addr); end
    at_rst = oam_wr;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_l = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (oam_wr != at_rst) begin errors++; $display("FAIL mid_extra_writes got %0d expected %0d", oam_wr, at_rst); end
    checks++; if (dut.idx !== 8'h00) begin errors++; $display("FAIL mid_idx got %h expected 00", dut.idx); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL mid_rdy_after got %b expected 1", cpu_rdy); end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_halt_writes();
    test_retrigger();
    test_page_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite OAM DMA controller and CPU-bus arbiter.
- Sits between the CPU core and the system bus (RAM, PPU registers).
- A CPU write to $4014 with page P halts the CPU. The block then owns the bus and copies 256 bytes from P00–PFF to the OAM data port $2004, then returns the bus to the CPU.
- Total stall is 513 or 514 cycles, depending on cycle parity, as on NES hardware.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clk  in  1  CPU cycle clock; one clk = one bus cycle.
- reset_l  in  1  async active-low reset.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data (DOR).
- cpu_r_w  in  1  CPU direction; 1=read, 0=write.
- cpu_rdy  out  1  1=CPU may proceed; 0=CPU must hold on its next read cycle.
- bus_addr  out  16  system bus address.
- bus_wdata  out  8  system bus write data.
- bus_r_w  out  1  system bus direction.
- bus_rdata  in  8  system bus read data.
- dma_active  out  1  high while the DMA owns the bus.

Behaviour:
- Reset (async, reset_l=0):
  - State IDLE; page=0, idx=0, latch=0, par=0.
  - cpu_rdy=1, dma_active=0, bus_* pass through cpu_*.
- Parity bit par:
  - Toggles every clk from reset.
  - par==0 marks a "get" cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - bus_* = cpu_* combinationally.
  - Trigger: cpu_r_w==0 && cpu_addr==DMA_REG_ADDR. On trigger, page<=cpu_wdata, idx<=0, next state HALT.
  - The triggering write still reaches the bus.
- HALT:
  - cpu_rdy=0; bus still passes through the CPU.
  - CPU writes (cpu_r_w==0) complete normally and the state stays HALT; the 6502 ignores RDY on writes.
  - On the first cycle with cpu_r_w==1, the CPU is halted; next state ALIGN.
- ALIGN:
  - DMA owns the bus and dma_active=1.
  - Dummy read: bus_addr=cpu_addr, bus_r_w=1; data discarded.
  - If par==1, next state READ; else stay.
  - ALIGN therefore lasts 1 or 2 cycles, and READ always lands on par==0.
- READ:
  - bus_addr={page,idx}, bus_r_w=1.
  - latch<=bus_rdata at the clock edge.
  - Next state WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_r_w=0, bus_wdata=latch.
  - idx<=idx+1 (8-bit wrap).
  - If idx==8'hFF, next state IDLE; else READ.
- Outputs by state:
  - cpu_rdy = (state==IDLE).
  - dma_active = state in {ALIGN, READ, WRITE}.
  - bus_wdata = cpu_wdata whenever the DMA does not own the bus.
- Latency:
  - Trigger write at cycle T; HALT from T+1.
  - Best-case first READ at T+3 (CPU reads at T+1, par at T+2 ==1).
  - The CPU resumes on the cycle after the last WRITE.
  - Total bus ownership is 1+512 or 2+512 cycles.
- Boundaries:
  - Writes to DMA_REG_ADDR outside IDLE are ignored: no restart, page unchanged.
  - Page FF is legal; idx wrap never changes page.
  - A DMA write landing on $4014 is impossible, since the destination is fixed.
  - Reset mid-transfer aborts immediately to reset values; no partial-completion state persists.
- Register all state/page/idx/latch/par; bus muxing is combinational from state.

Decomposition:
- Shared package nes_bus_pkg holds:
  - DMA_REG_ADDR and OAM_DATA_ADDR defaults, plus other PPU/APU register address constants.
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE}.
- No sub-module: a single FSM with an 8-bit counter and a parity flop.
- The cpu top instantiates oam_dma between the core and the external bus; the RDY input is added to control.

Test Plan:
- Reset mid-transfer: assert reset_l=0 at idx=8'h40 → state IDLE, cpu_rdy=1, dma_active=0 immediately (async); memory at $2004 receives no further writes.
- Basic copy, even alignment: preload RAM $0200–$02FF with byte i = i^8'h5A. CPU writes 8'h02 to $4014, then reads; par at the first ALIGN cycle ==1. Required:
  - 1 ALIGN cycle.
  - Exactly 256 writes to $2004 carrying 5A, 5B, …, A5 in order.
  - cpu_rdy low for exactly 514 cycles (HALT 1 + 513).
- Odd alignment: same stimulus, shifted one cycle so par==0 in the first ALIGN → 2 ALIGN cycles; first READ lands on par==0; total bus ownership 514 cycles.
- Write during HALT: the CPU issues two writes after the trigger (e.g. a stack push to $01FD, $01FC) before reading → both writes appear on the bus with cpu data; ALIGN starts only on the first read.
- Retrigger ignored: force cpu_addr=$4014, cpu_r_w=0, cpu_wdata=8'h07 during READ → page stays 8'h02, transfer count unchanged.
- Page wrap: trigger with page 8'hFF → source $FF00–$FFFF; after idx 8'hFF the controller returns to IDLE, and the last READ address is $FFFF, not $0000.
